// File: rtl/router_pkg.sv
// Shared types and constants for the 8x8 serial packet router.
package router_pkg;

    localparam int NPORTS    = 8;
    localparam int PAYLOAD_W = 32;
    localparam int ADDR_W    = 4;
    localparam int DEST_W    = 3;
    localparam int BIT_CNT_W = 5;

    // Index of the final payload bit, the one carried with frame deasserted.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PAYLOAD_W - 1);

    // Input deserializer states.
    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StPad,
        StData
    } in_state_e;

    // Output serializer states.
    typedef enum logic {
        StOutIdle,
        StOutSend
    } out_state_e;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    // Port index arithmetic wraps modulo NPORTS.
    function automatic logic [DEST_W-1:0] port_add(input logic [DEST_W-1:0] base,
                                                   input int unsigned offs);
        return base + DEST_W'(offs);
    endfunction

endpackage

// File: rtl/router_in_port.sv
// One router input: frame/valid deserializer feeding a packet FIFO.
// The FIFO head stays put until the owning output pops it after the last bit.
module router_in_port
    import router_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    frame_n,
    input  logic    valid_n,
    input  logic    di,
    input  logic    pop,
    output packet_t head,
    output logic    not_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    in_state_e              state_q;
    logic [BIT_CNT_W-1:0]   cnt_q;
    logic [DEST_W-1:0]      dest_q;
    logic [PAYLOAD_W-2:0]   shift_q;
    logic                   push;

    packet_t                mem [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_q;
    logic [PTR_W:0]         rd_ptr_q;
    logic                   full;
    logic                   empty;

    // Packet completes on the edge that samples bit 31 with frame released.
    assign push = (state_q == StData) && !valid_n && frame_n && (cnt_q == LAST_BIT);

    // Input framing FSM: address, optional padding, then 32 payload bits.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dest_q  <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!frame_n) begin
                        dest_q[0] <= di;
                        cnt_q     <= BIT_CNT_W'(1);
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    if (frame_n) begin
                        state_q <= StIdle;
                    end else begin
                        // Address bit 3 is sampled but not stored.
                        if (cnt_q < BIT_CNT_W'(DEST_W)) begin
                            dest_q[cnt_q[1:0]] <= di;
                        end
                        if (cnt_q == BIT_CNT_W'(ADDR_W - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StPad;
                        end else begin
                            cnt_q <= cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                StPad: begin
                    if (frame_n) begin
                        state_q <= StIdle;
                    end else if (!valid_n) begin
                        shift_q[0] <= di;
                        cnt_q      <= BIT_CNT_W'(1);
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (valid_n) begin
                        // Stall; a frame release without data truncates the packet.
                        if (frame_n) begin
                            state_q <= StIdle;
                        end
                    end else if (frame_n || (cnt_q == LAST_BIT)) begin
                        // Either the good end (push) or a short/long packet that is dropped.
                        state_q <= StIdle;
                    end else begin
                        shift_q[cnt_q] <= di;
                        cnt_q          <= cnt_q + BIT_CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign not_empty = !empty;
    assign head      = mem[rd_ptr_q[PTR_W-1:0]];

    // FIFO pointers; a push into a full FIFO is silently dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= '{dest: dest_q, payload: {di, shift_q}};
        end
    end

endmodule

// File: rtl/router.sv
// 8x8 bit-serial packet router.
// Each input buffers whole packets; each output arbitrates among FIFO heads
// addressed to it and replays the packet LSB first.
// Build option: define ROUTER_RR_ARB_EN for round-robin output arbitration;
// otherwise the lowest-numbered requesting input wins.
module router
    import router_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NPORTS-1:0] frame_n,
    input  logic [NPORTS-1:0] valid_n,
    input  logic [NPORTS-1:0] di,
    output logic [NPORTS-1:0] dout,
    output logic [NPORTS-1:0] valido_n,
    output logic [NPORTS-1:0] frameo_n
);

    packet_t              head      [NPORTS];
    logic [NPORTS-1:0]    not_empty;
    logic [NPORTS-1:0]    pop;

    out_state_e           out_state_q [NPORTS];
    logic [DEST_W-1:0]    sel_q       [NPORTS];
    logic [BIT_CNT_W-1:0] out_cnt_q   [NPORTS];
    logic [NPORTS-1:0]    dout_q;
    logic [NPORTS-1:0]    valido_n_q;
    logic [NPORTS-1:0]    frameo_n_q;

`ifdef ROUTER_RR_ARB_EN
    logic [DEST_W-1:0]    last_q      [NPORTS];
`endif

    logic [NPORTS-1:0]    grant_vld;
    logic [DEST_W-1:0]    grant_idx   [NPORTS];
    logic [DEST_W-1:0]    arb_start;
    logic [DEST_W-1:0]    arb_idx;

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        router_in_port #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_in_port (
            .clock     (clock),
            .reset_n   (reset_n),
            .frame_n   (frame_n[i]),
            .valid_n   (valid_n[i]),
            .di        (di[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .not_empty (not_empty[i])
        );
    end

    // Per-output arbitration over FIFO heads addressed to it, only while idle.
    always_comb begin
        arb_start = '0;
        arb_idx   = '0;
        grant_vld = '0;
        for (int o = 0; o < NPORTS; o++) begin
            grant_idx[o] = '0;
`ifdef ROUTER_RR_ARB_EN
            // Search starts just past the last winner, so it ranks lowest.
            arb_start = port_add(last_q[o], 1);
`else
            arb_start = '0;
`endif
            for (int k = 0; k < NPORTS; k++) begin
                arb_idx = port_add(arb_start, k);
                if (!grant_vld[o] && (out_state_q[o] == StOutIdle) && not_empty[arb_idx] &&
                    (head[arb_idx].dest == DEST_W'(o))) begin
                    grant_vld[o] = 1'b1;
                    grant_idx[o] = arb_idx;
                end
            end
        end
    end

    // The head is released on the same edge that drives its final bit.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if ((out_state_q[o] == StOutSend) && (out_cnt_q[o] == LAST_BIT)) begin
                pop[sel_q[o]] = 1'b1;
            end
        end
    end

    // Output serializers; idle state forces at least one idle cycle between packets.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int o = 0; o < NPORTS; o++) begin
                out_state_q[o] <= StOutIdle;
                sel_q[o]       <= '0;
                out_cnt_q[o]   <= '0;
`ifdef ROUTER_RR_ARB_EN
                last_q[o]      <= DEST_W'(NPORTS - 1);
`endif
            end
            dout_q     <= '0;
            valido_n_q <= '1;
            frameo_n_q <= '1;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                case (out_state_q[o])
                    StOutIdle: begin
                        dout_q[o]     <= 1'b0;
                        valido_n_q[o] <= 1'b1;
                        frameo_n_q[o] <= 1'b1;
                        if (grant_vld[o]) begin
                            sel_q[o]       <= grant_idx[o];
                            out_cnt_q[o]   <= '0;
                            out_state_q[o] <= StOutSend;
`ifdef ROUTER_RR_ARB_EN
                            last_q[o]      <= grant_idx[o];
`endif
                        end
                    end
                    StOutSend: begin
                        dout_q[o]     <= head[sel_q[o]].payload[out_cnt_q[o]];
                        valido_n_q[o] <= 1'b0;
                        frameo_n_q[o] <= (out_cnt_q[o] == LAST_BIT);
                        out_cnt_q[o]  <= out_cnt_q[o] + BIT_CNT_W'(1);
                        if (out_cnt_q[o] == LAST_BIT) begin
                            out_state_q[o] <= StOutIdle;
                        end
                    end
                    default: out_state_q[o] <= StOutIdle;
                endcase
            end
        end
    end

    assign dout     = dout_q;
    assign valido_n = valido_n_q;
    assign frameo_n = frameo_n_q;

endmodule

// File: tb/tb_router.sv
// Randomized bench for router: per-input symbol streams, per-(source,dest)
// expected payload queues, and a per-output framing monitor.
module tb_router;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned SBUF       = 1024;
    localparam int unsigned EDEPTH     = 64;
    localparam int unsigned GUARD      = 20000;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] frame_n, valid_n, di;
    logic [7:0] dout, valido_n, frameo_n;

    router #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .frame_n  (frame_n),
        .valid_n  (valid_n),
        .di       (di),
        .dout     (dout),
        .valido_n (valido_n),
        .frameo_n (frameo_n)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int ticks   = 0;

    // Stimulus symbol: {last_bit_marker, frame_n, valid_n, di}.
    logic [3:0]  stim   [8][SBUF];
    int          s_wr   [8];
    int          s_rd   [8];
    logic [31:0] exp_pl [8][8][EDEPTH];
    int          e_wr   [8][8];
    int          e_rd   [8][8];

    int          rx_bit   [8];
    logic [31:0] rx_data  [8];
    logic [31:0] rx_last  [8];
    bit          prev_vld [8];
    int          rcvd     [8];
    int          rx_start [8];
    int          last_tick[8];
    int          act_cnt = 0;
    int          base     [8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pending_src(input int s);
        int n = 0;
        for (int d = 0; d < 8; d++) n += e_wr[s][d] - e_rd[s][d];
        return n;
    endfunction

    function automatic int pending_all();
        int n = 0;
        for (int s = 0; s < 8; s++) n += pending_src(s);
        return n;
    endfunction

    task automatic push_sym(input int s, input logic [3:0] sym);
        stim[s][s_wr[s] % SBUF] = sym;
        s_wr[s]++;
    endtask

    // Accept only if it equals the oldest outstanding packet of some source.
    task automatic match_pkt(input int o, input logic [31:0] data);
        bit found = 1'b0;
        for (int s = 0; s < 8; s++) begin
            if (!found && e_rd[s][o] < e_wr[s][o] &&
                exp_pl[s][o][e_rd[s][o] % EDEPTH] == data) begin
                found = 1'b1;
                e_rd[s][o]++;
            end
        end
        check_eq($sformatf("match out%0d data %08h", o, data), 64'(found), 64'd1);
        rx_last[o] = data;
        rcvd[o]++;
    endtask

    // One cycle: sample outputs at the falling edge, then drive next input symbols.
    task automatic tick();
        logic [3:0] sym;
        @(negedge clock);
        ticks++;
        for (int o = 0; o < 8; o++) begin
            if (valido_n[o] == 1'b0) begin
                act_cnt++;
                if (rx_bit[o] == 0) begin
                    check_eq($sformatf("gap out%0d", o), 64'(prev_vld[o]), 64'd0);
                    rx_start[o] = ticks;
                end
                rx_data[o][rx_bit[o]] = dout[o];
                check_eq($sformatf("frameo out%0d bit%0d", o, rx_bit[o]),
                         64'(frameo_n[o]), 64'(rx_bit[o] == 31));
                if (rx_bit[o] == 31) begin
                    match_pkt(o, rx_data[o]);
                    rx_bit[o] = 0;
                end else begin
                    rx_bit[o]++;
                end
                prev_vld[o] = 1'b1;
            end else begin
                check_eq($sformatf("idle out%0d", o),
                         64'({rx_bit[o] != 0, frameo_n[o], dout[o]}), 64'b010);
                rx_bit[o]   = 0;
                prev_vld[o] = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (s_rd[i] != s_wr[i]) begin
                sym = stim[i][s_rd[i] % SBUF];
                s_rd[i]++;
                if (sym[3]) last_tick[i] = ticks;
            end else begin
                sym = 4'b0110;
            end
            frame_n[i] = sym[2];
            valid_n[i] = sym[1];
            di[i]      = sym[0];
        end
    endtask

    task automatic send(input int s, input logic [3:0] addr, input logic [31:0] pl,
                        input int npad, input bit stall);
        int guard = 0;
        // Keep the source FIFO from overflowing: nothing may be dropped.
        while (pending_src(s) >= int'(FIFO_DEPTH) - 1 && guard < GUARD) begin
            tick();
            guard++;
        end
        check_eq($sformatf("throttle src%0d", s), 64'(pending_src(s) < int'(FIFO_DEPTH) - 1),
                 64'd1);
        for (int k = 0; k < 4; k++) push_sym(s, {2'b00, 1'b1, addr[k]});
        for (int k = 0; k < npad; k++) push_sym(s, 4'b0010);
        for (int k = 0; k < 32; k++) begin
            if (stall && k > 0 && $urandom_range(0, 3) == 0) push_sym(s, 4'b0010);
            push_sym(s, {k == 31, k == 31, 1'b0, pl[k]});
        end
        push_sym(s, 4'b0110);
        exp_pl[s][addr[2:0]][e_wr[s][addr[2:0]] % EDEPTH] = pl;
        e_wr[s][addr[2:0]]++;
    endtask

    task automatic drain();
        int guard = 0;
        while (pending_all() > 0 && guard < GUARD) begin
            tick();
            guard++;
        end
        check_eq("drain", 64'(pending_all()), 64'd0);
        repeat (5) tick();
    endtask

    task automatic snap();
        for (int o = 0; o < 8; o++) base[o] = rcvd[o];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pl;
        int          act0;
        int          tot0;
        reset_n = 1'b0;
        frame_n = '1;
        valid_n = '1;
        di      = '0;
        repeat (3) tick();
        check_eq("rst dout", 64'(dout), 64'h00);
        check_eq("rst valido_n", 64'(valido_n), 64'hff);
        check_eq("rst frameo_n", 64'(frameo_n), 64'hff);
        reset_n = 1'b1;
        repeat (2) tick();

        // Smoke: 0 -> 7, latency and isolation.
        snap();
        send(0, 4'd7, 32'hDEADBEEF, 0, 0);
        drain();
        check_eq("smoke count", 64'(rcvd[7] - base[7]), 64'd1);
        check_eq("smoke payload", 64'(rx_last[7]), 64'hDEADBEEF);
        check_eq("smoke latency", 64'(rx_start[7] - last_tick[0]), 64'd3);
        for (int o = 0; o < 7; o++)
            check_eq($sformatf("smoke quiet out%0d", o), 64'(rcvd[o] - base[o]), 64'd0);

        // Sweep: input 0 to every destination.
        snap();
        for (int d = 0; d < 8; d++) begin
            pl = (d == 0) ? 32'h12341234 : (d == 1) ? 32'hDEADBEEF : 32'($urandom);
            send(0, 4'(d), pl, $urandom_range(0, 3), 1'b1);
        end
        drain();
        for (int d = 0; d < 8; d++)
            check_eq($sformatf("sweep out%0d", d), 64'(rcvd[d] - base[d]), 64'd1);

        // Disjoint pairs running concurrently.
        snap();
        for (int p = 0; p < 10; p++)
            for (int s = 0; s < 4; s++)
                send(s, 4'(3 - s), 32'($urandom), $urandom_range(0, 3), 1'b1);
        drain();
        for (int o = 0; o < 4; o++)
            check_eq($sformatf("disjoint out%0d", o), 64'(rcvd[o] - base[o]), 64'd10);

        // Contention: four sources onto output 7.
        snap();
        for (int p = 0; p < 10; p++)
            for (int s = 0; s < 4; s++)
                send(s, 4'd7, 32'($urandom), $urandom_range(0, 3), 1'b1);
        drain();
        check_eq("contention out7", 64'(rcvd[7] - base[7]), 64'd40);

        // Reset in the middle of an input payload.
        snap();
        send(0, 4'd5, 32'($urandom), 0, 1'b0);
        repeat (20) tick();
        reset_n = 1'b0;
        s_rd[0] = s_wr[0];
        for (int d = 0; d < 8; d++) e_rd[0][d] = e_wr[0][d];
        act0 = act_cnt;
        tot0 = 0;
        for (int o = 0; o < 8; o++) tot0 += rcvd[o];
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (60) tick();
        begin
            int tot1 = 0;
            for (int o = 0; o < 8; o++) tot1 += rcvd[o];
            check_eq("reset no rx", 64'(tot1 - tot0), 64'd0);
        end
        check_eq("reset no activity", 64'(act_cnt - act0), 64'd0);
        pl = 32'($urandom);
        send(0, 4'd5, pl, 1, 1'b1);
        drain();
        check_eq("post-reset count", 64'(rcvd[5] - base[5]), 64'd1);
        check_eq("post-reset payload", 64'(rx_last[5]), 64'(pl));

        // Address bit 3 is ignored.
        snap();
        pl = 32'($urandom);
        send(1, 4'd8, pl, 2, 1'b1);
        drain();
        check_eq("addr8 count", 64'(rcvd[0] - base[0]), 64'd1);
        check_eq("addr8 payload", 64'(rx_last[0]), 64'(pl));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
